ballot_sequencer: RTL and testbench
===================================

Name: ballot_sequencer

Overview:
Controls the vote-accumulation datapath between the SPI receiver and the accumulator BRAM, multiplier and Montgomery reducer.
- Admits exactly one ballot's ciphertext blocks at a time and paces accumulator reads against them.
- Waits for the reducer to write the full product back before admitting the next ballot.
- On a tally request, waits for a ballot boundary, then asserts flush into the results pipeline and tracks completion.
- Keeps ballot, dropped-block and error status for the top level.

Parameters:
NUM_BLOCKS, 128, register-size blocks per ciphertext (N_SQUARED_SIZE/REGISTER_SIZE); must be >= 2.
COUNT_WIDTH, 16, width of ballot_count_out and drop_count_out.
TIMEOUT_CYCLES, 4194304, maximum cycles between writeback events before an error is declared.

Ports:
clk_in  input  1  system clock (clk_100mhz domain).
rst_in  input  1  synchronous active-high reset.
block_valid_in  input  1  SPI receiver has a ciphertext block this cycle.
tally_req_in  input  1  request to end voting; level or pulse.
accum_write_valid_in  input  1  reducer wrote one block back into the accumulator.
result_done_in  input  1  single-cycle pulse: results pipeline finished output.
block_accept_out  output  1  forward block to the multiplier (combinational).
read_next_out  output  1  advance the accumulator read pointer (combinational, equals block_accept_out).
flush_out  output  1  level: drive accumulator flush / results path.
busy_out  output  1  high in any state except S_RECV with block index 0.
done_out  output  1  high in S_DONE.
error_out  output  1  sticky writeback-timeout flag.
ballot_count_out  output  COUNT_WIDTH  completed ballots, saturating.
drop_count_out  output  COUNT_WIDTH  blocks refused, saturating.

Behaviour:
- Reset: state=S_RECV, blk_idx=0, wb_idx=0, tally_pending=0, all counters=0.
  - block_accept_out=read_next_out=0 (follows the reset state and the low input).
  - flush_out, done_out and error_out are 0.
- States: S_RECV, S_WB, S_RESULTS, S_DONE, S_ERROR. All transitions are registered.
- tally_pending is set when tally_req_in=1 in S_RECV or S_WB. It is cleared only by reset.
- S_RECV:
  - block_accept_out = block_valid_in; zero latency, so data passes straight through.
  - Each accepted block increments blk_idx.
  - On acceptance with blk_idx==NUM_BLOCKS-1: blk_idx<=0, wb_idx<=0, timer<=0, go to S_WB.
  - If blk_idx==0 and (tally_pending or tally_req_in) and block_valid_in=0: go to S_RESULTS.
  - If blk_idx==0 and a tally request coincides with block_valid_in: the block is dropped (drop_count++), then go to S_RESULTS.
  - A tally request with blk_idx!=0 only latches pending; the ballot completes first.
- S_WB:
  - block_accept_out=0.
  - Every block_valid_in increments drop_count_out.
  - Each accum_write_valid_in increments wb_idx and resets timer; otherwise timer increments.
  - On the write with wb_idx==NUM_BLOCKS-1: ballot_count++ (saturating), then go to S_RESULTS if tally_pending or tally_req_in is set this cycle, else S_RECV.
  - If timer reaches TIMEOUT_CYCLES-1 with no write: error_out<=1, go to S_ERROR.
  - A write and a block_valid_in in the same cycle as the final write: the block is dropped, because the state changes only next edge.
- S_RESULTS:
  - flush_out=1.
  - Blocks are dropped and counted; accum_write_valid_in is ignored.
  - result_done_in -> S_DONE.
- S_DONE: done_out=1, flush_out=0. Blocks are dropped and counted. Exit only by reset.
- S_ERROR: all enables are 0, error_out=1. Blocks are dropped and counted. Exit only by reset.
- Counters saturate at all-ones; no wrap.
- Reset mid-ballot or mid-writeback discards partial progress. Accumulator contents are not touched by this block.
- accum_write_valid_in in S_RECV is a protocol violation: error_out<=1, go to S_ERROR.

Decomposition:
- Shared package (e.g. election_pkg): state enum ballot_seq_state_t; the size localparams REGISTER_SIZE, N_SQUARED_SIZE and NUM_N_SQUARED_BLOCKS, used for the NUM_BLOCKS default.
- One natural sub-module, sat_counter (parameterised width, increment enable, saturates), instantiated for ballot_count and drop_count.
- The block counters reuse the existing evt_counter.

Test Plan (NUM_BLOCKS=4, TIMEOUT_CYCLES=64):
1. After reset, 4 consecutive block_valid_in -> 4 accept pulses, busy_out=1, state S_WB. Then 4 writes -> ballot_count_out=1, busy_out=0.
2. In S_WB send 3 block_valid_in before the writes complete -> 0 accepts, drop_count_out=3. Next ballot is accepted normally.
3. Pulse tally_req_in after 2 of 4 blocks -> remaining 2 accepted, 4 writes, then flush_out=1. result_done_in pulse -> done_out=1, flush_out=0.
4. Tally at idle coincident with block_valid_in -> accept=0, drop_count_out=1, flush_out=1 next cycle.
5. In S_WB give 2 writes then silence -> error_out=1 at the 64th idle cycle. Later block_valid_in is not accepted. rst_in clears everything.
6. Reset asserted mid-ballot (blk_idx=2) -> all outputs 0. A fresh 4-block ballot completes with ballot_count_out=1.

Source files
------------

// File: rtl/ballot_sequencer_pkg.sv
// Shared definitions for the vote-accumulation sequencer.
// Contents: ciphertext size constants and the sequencer state enum.
package ballot_sequencer_pkg;

   localparam int REGISTER_SIZE        = 32;
   localparam int N_SQUARED_SIZE       = 4096;
   localparam int NUM_N_SQUARED_BLOCKS = N_SQUARED_SIZE / REGISTER_SIZE;

   typedef enum logic [2:0] {
      S_RECV    = 3'd0,
      S_WB      = 3'd1,
      S_RESULTS = 3'd2,
      S_DONE    = 3'd3,
      S_ERROR   = 3'd4
   } ballot_seq_state_t;

endpackage

// File: rtl/ballot_sequencer_if.sv
// Handshake/status bundle between the ballot sequencer and its surroundings.
// master: the SPI receiver, the reducer and the results pipeline taken as a group
//         (they drive the *_in signals).
// slave : the sequencer (it drives the *_out signals).
interface ballot_sequencer_if #(
   parameter int COUNT_WIDTH = 16
);
   logic                   block_valid_in;
   logic                   tally_req_in;
   logic                   accum_write_valid_in;
   logic                   result_done_in;
   logic                   block_accept_out;
   logic                   read_next_out;
   logic                   flush_out;
   logic                   busy_out;
   logic                   done_out;
   logic                   error_out;
   logic [COUNT_WIDTH-1:0] ballot_count_out;
   logic [COUNT_WIDTH-1:0] drop_count_out;

   modport master (
      output block_valid_in, tally_req_in, accum_write_valid_in, result_done_in,
      input  block_accept_out, read_next_out, flush_out, busy_out, done_out,
             error_out, ballot_count_out, drop_count_out
   );

   modport slave (
      input  block_valid_in, tally_req_in, accum_write_valid_in, result_done_in,
      output block_accept_out, read_next_out, flush_out, busy_out, done_out,
             error_out, ballot_count_out, drop_count_out
   );
endinterface

// File: rtl/ballot_sequencer_sat_counter.sv
// Saturating up-counter: counts inc_in pulses and holds at all-ones.
// Ports: clk_in, rst_in (sync, active high), inc_in, count_out.
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             inc_in,
   output logic [WIDTH-1:0] count_out
);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         count_out <= '0;
      end else if (inc_in && (count_out != '1)) begin
         count_out <= count_out + 1'b1;
      end
   end

endmodule

// File: rtl/ballot_sequencer.sv
// Ballot sequencer: admits one ciphertext at a time, paces accumulator reads,
// waits for the reduced product to be written back, then on a tally request
// flushes the results pipeline. Reports ballot, dropped-block and error status.
// Ports: clk_in, rst_in (sync, active high), bus (ballot_sequencer_if.slave).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_RECV    | accepting blocks of the current ballot (idle when blk_idx=0)
// S_WB      | waiting for the reducer to write all blocks back
// S_RESULTS | flush asserted, waiting for result_done_in
// S_DONE    | results finished; left only by reset
// S_ERROR   | writeback timeout or protocol violation; left only by reset
module ballot_sequencer
   import ballot_sequencer_pkg::*;
#(
   parameter int NUM_BLOCKS     = NUM_N_SQUARED_BLOCKS,
   parameter int COUNT_WIDTH    = 16,
   parameter int TIMEOUT_CYCLES = 4194304
) (
   input  logic               clk_in,
   input  logic               rst_in,
   ballot_sequencer_if.slave  bus
);

   localparam int IDX_W = (NUM_BLOCKS > 2) ? $clog2(NUM_BLOCKS) : 1;
   localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   ballot_seq_state_t state, state_nxt;
   logic [IDX_W-1:0]  blk_idx, blk_idx_nxt;
   logic [IDX_W-1:0]  wb_idx, wb_idx_nxt;
   logic [TMR_W-1:0]  timer, timer_nxt;
   logic              tally_pending, tally_pending_nxt;
   logic              error_q, error_nxt;
   logic              accept;
   logic              drop_inc;
   logic              ballot_inc;
   logic              tally_any;

   assign tally_any = tally_pending | bus.tally_req_in;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state         <= S_RECV;
         blk_idx       <= '0;
         wb_idx        <= '0;
         timer         <= '0;
         tally_pending <= 1'b0;
         error_q       <= 1'b0;
      end else begin
         state         <= state_nxt;
         blk_idx       <= blk_idx_nxt;
         wb_idx        <= wb_idx_nxt;
         timer         <= timer_nxt;
         tally_pending <= tally_pending_nxt;
         error_q       <= error_nxt;
      end
   end

   always_comb begin
      state_nxt         = state;
      blk_idx_nxt       = blk_idx;
      wb_idx_nxt        = wb_idx;
      timer_nxt         = timer;
      tally_pending_nxt = tally_pending;
      error_nxt         = error_q;
      accept            = 1'b0;
      drop_inc          = 1'b0;
      ballot_inc        = 1'b0;

      case (state)
         S_RECV: begin
            tally_pending_nxt = tally_any;
            if ((blk_idx == '0) && tally_any) begin
               // Ballot boundary: a block arriving with the tally is refused.
               drop_inc  = bus.block_valid_in;
               state_nxt = S_RESULTS;
            end else begin
               accept = bus.block_valid_in;
               if (bus.block_valid_in) begin
                  if (blk_idx == LAST_IDX) begin
                     blk_idx_nxt = '0;
                     wb_idx_nxt  = '0;
                     timer_nxt   = '0;
                     state_nxt   = S_WB;
                  end else begin
                     blk_idx_nxt = blk_idx + 1'b1;
                  end
               end
            end
            // The reducer has nothing to write back while blocks are arriving.
            if (bus.accum_write_valid_in) begin
               error_nxt = 1'b1;
               state_nxt = S_ERROR;
            end
         end

         S_WB: begin
            tally_pending_nxt = tally_any;
            drop_inc          = bus.block_valid_in;
            if (bus.accum_write_valid_in) begin
               timer_nxt = '0;
               if (wb_idx == LAST_IDX) begin
                  wb_idx_nxt = '0;
                  ballot_inc = 1'b1;
                  state_nxt  = tally_any ? S_RESULTS : S_RECV;
               end else begin
                  wb_idx_nxt = wb_idx + 1'b1;
               end
            end else if (timer == TMR_LAST) begin
               error_nxt = 1'b1;
               state_nxt = S_ERROR;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end

         S_RESULTS: begin
            drop_inc = bus.block_valid_in;
            if (bus.result_done_in) begin
               state_nxt = S_DONE;
            end
         end

         S_DONE: begin
            drop_inc = bus.block_valid_in;
         end

         S_ERROR: begin
            drop_inc = bus.block_valid_in;
         end

         default: begin
            error_nxt = 1'b1;
            state_nxt = S_ERROR;
         end
      endcase
   end

   assign bus.block_accept_out = accept;
   assign bus.read_next_out    = accept;
   assign bus.flush_out        = (state == S_RESULTS);
   assign bus.done_out         = (state == S_DONE);
   assign bus.busy_out         = !((state == S_RECV) && (blk_idx == '0));
   assign bus.error_out        = error_q;

   sat_counter #(.WIDTH(COUNT_WIDTH)) u_ballot_count (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .inc_in    (ballot_inc),
      .count_out (bus.ballot_count_out)
   );

   sat_counter #(.WIDTH(COUNT_WIDTH)) u_drop_count (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .inc_in    (drop_inc),
      .count_out (bus.drop_count_out)
   );

endmodule

// File: tb/tb_ballot_sequencer.sv
// Scoreboard bench for ballot_sequencer with NUM_BLOCKS=4, TIMEOUT_CYCLES=64.
module tb_ballot_sequencer;

   typedef struct {
      string       name;
      logic        acc;
      logic        busy;
      logic        flush;
      logic        done;
      logic        err;
      logic [15:0] bc;
      logic [15:0] dc;
   } stat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_mis = 0;

   logic  acc_q[$];
   stat_t stat_q[$];

   always #5 clk = ~clk;

   ballot_sequencer_if #(.COUNT_WIDTH(16)) bus ();

   ballot_sequencer #(
      .NUM_BLOCKS     (4),
      .COUNT_WIDTH    (16),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk_in (clk),
      .rst_in (rst),
      .bus    (bus)
   );

   // Monitor: compares accept on every offered block and status snapshots.
   always @(negedge clk) begin
      if (!rst && bus.block_valid_in) begin
         n_cmp++;
         if (acc_q.size() == 0) begin
            n_mis++;
            $display("FAIL accept_unexpected: block offered with no expectation queued");
         end else begin
            logic e;
            e = acc_q.pop_front();
            if (bus.block_accept_out !== e || bus.read_next_out !== e) begin
               n_mis++;
               $display("FAIL accept: got accept=%b read_next=%b, want %b",
                        bus.block_accept_out, bus.read_next_out, e);
            end
         end
      end
      if (stat_q.size() > 0) begin
         stat_t s;
         s = stat_q.pop_front();
         n_cmp++;
         if (bus.block_accept_out !== s.acc || bus.busy_out !== s.busy ||
             bus.flush_out !== s.flush || bus.done_out !== s.done ||
             bus.error_out !== s.err || bus.ballot_count_out !== s.bc ||
             bus.drop_count_out !== s.dc) begin
            n_mis++;
            $display("FAIL %s: got acc=%b busy=%b flush=%b done=%b err=%b bc=%0d dc=%0d, want acc=%b busy=%b flush=%b done=%b err=%b bc=%0d dc=%0d",
                     s.name, bus.block_accept_out, bus.busy_out, bus.flush_out,
                     bus.done_out, bus.error_out, bus.ballot_count_out,
                     bus.drop_count_out, s.acc, s.busy, s.flush, s.done, s.err,
                     s.bc, s.dc);
         end
      end
   end

   task automatic step(input logic bv, input logic tr, input logic wr,
                       input logic rd, input logic exp_acc);
      bus.block_valid_in       = bv;
      bus.tally_req_in         = tr;
      bus.accum_write_valid_in = wr;
      bus.result_done_in       = rd;
      if (bv) acc_q.push_back(exp_acc);
      @(posedge clk);
      #1;
      bus.block_valid_in       = 1'b0;
      bus.tally_req_in         = 1'b0;
      bus.accum_write_valid_in = 1'b0;
      bus.result_done_in       = 1'b0;
   endtask

   task automatic expect_status(input string name, input logic busy,
                                input logic flush, input logic done,
                                input logic err, input int bc, input int dc);
      stat_t s;
      s.name  = name;
      s.acc   = 1'b0;
      s.busy  = busy;
      s.flush = flush;
      s.done  = done;
      s.err   = err;
      s.bc    = 16'(bc);
      s.dc    = 16'(dc);
      stat_q.push_back(s);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic blocks(input int n, input logic exp_acc);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, exp_acc);
   endtask

   task automatic writes(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.block_valid_in       = 1'b0;
      bus.tally_req_in         = 1'b0;
      bus.accum_write_valid_in = 1'b0;
      bus.result_done_in       = 1'b0;
      do_reset();

      // 1: basic ballot
      expect_status("reset_state", 0, 0, 0, 0, 0, 0);
      blocks(4, 1'b1);
      expect_status("t1_in_wb", 1, 0, 0, 0, 0, 0);
      writes(4);
      expect_status("t1_done_ballot", 0, 0, 0, 0, 1, 0);

      // 2: blocks during writeback are dropped
      blocks(4, 1'b1);
      blocks(3, 1'b0);
      expect_status("t2_drops", 1, 0, 0, 0, 1, 3);
      writes(4);
      expect_status("t2_ballot2", 0, 0, 0, 0, 2, 3);
      blocks(4, 1'b1);
      writes(4);
      expect_status("t2_ballot3", 0, 0, 0, 0, 3, 3);

      // 3: tally mid-ballot waits for the ballot to finish
      blocks(2, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      blocks(2, 1'b1);
      expect_status("t3_wb_pending", 1, 0, 0, 0, 3, 3);
      writes(4);
      expect_status("t3_flush", 1, 1, 0, 0, 4, 3);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_status("t3_done", 1, 0, 1, 0, 4, 4);

      // 4: tally at idle with a coincident block
      do_reset();
      expect_status("t4_reset", 0, 0, 0, 0, 0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      expect_status("t4_flush", 1, 1, 0, 0, 0, 1);

      // 5: writeback timeout
      do_reset();
      blocks(4, 1'b1);
      writes(2);
      repeat (63) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_status("t5_before_timeout", 1, 0, 0, 0, 0, 0);
      expect_status("t5_timeout", 1, 0, 0, 1, 0, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      expect_status("t5_error_drop", 1, 0, 0, 1, 0, 1);
      do_reset();
      expect_status("t5_reset_clears", 0, 0, 0, 0, 0, 0);

      // 6: reset mid-ballot
      blocks(2, 1'b1);
      do_reset();
      expect_status("t6_reset_mid", 0, 0, 0, 0, 0, 0);
      blocks(4, 1'b1);
      writes(4);
      expect_status("t6_fresh_ballot", 0, 0, 0, 0, 1, 0);

      // 7: writeback while receiving is a protocol error
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      expect_status("t7_protocol_err", 1, 0, 0, 1, 1, 0);

      repeat (2) @(posedge clk);
      n_cmp++;
      if (acc_q.size() != 0 || stat_q.size() != 0) begin
         n_mis++;
         $display("FAIL queues_drained: got acc_q=%0d stat_q=%0d left, want 0 0",
                  acc_q.size(), stat_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
